// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side consumer for a synchronous FIFO with 1-cycle
// registered read latency. Issues reads against a credit count (buffered +
// in-flight words) so the skid buffer can never overflow, and re-presents the
// words on a valid/ready stream. fifo_rd_en depends only on registered state
// and fifo_empty, so m_ready never reaches the FIFO combinationally.
module fifo_stream_reader #(
    parameter int WIDTH      = 3,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_CMP = (OCC_W + 1)'(SKID_DEPTH);

    // Registered state
    logic                 run_reg;       // low during reset and its first clock
    logic                 inflight_reg;  // read issued last cycle, data arrives now
    logic [OCC_W-1:0]     occ_reg, occ_next;
    logic [PTR_W-1:0]     head_reg, head_next;
    logic [PTR_W-1:0]     tail_reg, tail_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]     mem [SKID_DEPTH];

    logic                 capture;
    logic                 pop;
    logic [OCC_W:0]       credit_sum;

    // Circular pointer advance, wrapping at SKID_DEPTH (need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Read request and stream-side outputs from registered state only
    always_comb begin
        credit_sum = {1'b0, occ_reg} + {{OCC_W{1'b0}}, inflight_reg};
        fifo_rd_en = run_reg && !fifo_empty && (credit_sum < DEPTH_CMP);
        m_valid    = (occ_reg != '0);
        m_data     = mem[head_reg];
        word_cnt   = cnt_reg;
        capture    = inflight_reg;
        pop        = m_valid && m_ready;
    end

    // Next-state for occupancy, pointers and delivered-word counter
    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        tail_next = tail_reg;
        cnt_next  = cnt_reg;
        if (capture && !pop) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (!capture && pop) begin
            occ_next = occ_reg - OCC_W'(1);
        end
        if (capture) begin
            tail_next = ptr_inc(tail_reg);
        end
        if (pop) begin
            head_next = ptr_inc(head_reg);
            cnt_next  = cnt_reg + CNT_W'(1);
        end
    end

    // State registers; reset discards buffered and in-flight words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg      <= 1'b0;
            inflight_reg <= 1'b0;
            occ_reg      <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            run_reg      <= 1'b1;
            inflight_reg <= fifo_rd_en;
            occ_reg      <= occ_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Skid buffer storage: the word read last cycle lands at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (capture) begin
            mem[tail_reg] <= fifo_data;
        end
    end

endmodule
